tick_scheduler: RTL and testbench
=================================

TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 SHALL have parameter TICK_COUNT, default 4, timer expirations per event (legal 1..255).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of event sequence and overrun counters.
REQ-003 SHALL have port clock_in  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_in  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port enable_in  input  1  level; high requests scheduling, low requests stop.
REQ-006 SHALL have port tick_in  input  1  expiry flag from the upstream countdown timer (int_out).
REQ-007 SHALL have port timer_start_out  output  1  level to the timer start input; high keeps the timer counting.
REQ-008 SHALL have port event_valid_out  output  1  event pending toward the consumer.
REQ-009 SHALL have port event_ready_in  input  1  consumer accepts the event.
REQ-010 SHALL have port event_seq_out  output  CNT_WIDTH  sequence number of the pending event.
REQ-011 SHALL have port busy_out  output  1  high in any state other than IDLE.
REQ-012 SHALL have port overrun_count_out  output  CNT_WIDTH  dropped-event count (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, ARM, RUN; all outputs registered.
REQ-014 IDLE: timer_start_out=0; enable_in=1 -> ARM next cycle.
REQ-015 ARM: exactly one cycle; timer_start_out=1, tick counter cleared; -> RUN unconditionally.
REQ-016 RUN: timer_start_out=1; enable_in=0 -> IDLE next cycle, tick counter cleared, timer_start_out=0.
REQ-017 SHALL register tick_in every cycle in all states; tick edge = tick_in=1 and previous sample=0; a held-high tick_in counts once.
REQ-018 Tick edges SHALL be counted only in RUN; edges in IDLE/ARM ignored.
REQ-019 On the TICK_COUNT-th edge in RUN the tick counter SHALL return to 0 and an event SHALL be generated; event_valid_out rises on the same clock edge that samples the tick edge (one-cycle latency from tick_in rising).
REQ-020 Generating an event SHALL increment event_seq_out (mod 2^CNT_WIDTH, wraps 2^CNT_WIDTH-1 -> 0); first event after reset carries 1.
REQ-021 event_valid_out and event_seq_out SHALL stay stable until a clock edge with event_ready_in=1.
REQ-022 Event generated while event_valid_out=1 and event_ready_in=0 SHALL be dropped: event_seq_out unchanged, overrun recorded.
REQ-023 Event generated on the same edge as acceptance (valid=1, ready=1) SHALL keep event_valid_out=1 with incremented event_seq_out; no overrun.
REQ-024 event_ready_in while event_valid_out=0 SHALL have no effect.
REQ-025 A pending event SHALL survive transitions to IDLE; only reset_in clears it.
REQ-026 enable_in=0 on the same cycle as the TICK_COUNT-th edge: event generated, then -> IDLE.
REQ-027 TICK_COUNT=1: every tick edge in RUN generates an event.

Reset
REQ-028 reset_in=1 SHALL immediately force IDLE, timer_start_out=0, event_valid_out=0, event_seq_out=0, busy_out=0, overrun_count_out=0, tick counter=0, tick sample=0.
REQ-029 Reset asserted mid-RUN or with an event pending SHALL discard all state; operation resumes only via IDLE -> ARM.

Configuration
REQ-030 Macro TICK_SCHEDULER_OVERRUN_CNT_EN defined: overrun_count_out SHALL increment per dropped event, saturating at 2^CNT_WIDTH-1.
REQ-031 Macro undefined: overrun_count_out SHALL be tied to 0, no counter logic; dropping per REQ-022 unchanged.

Verification
REQ-032 TICK_COUNT=4, enable_in=1, four tick_in 1-cycle pulses, ready=1 -> single event_valid_out pulse 1 cycle after 4th pulse, event_seq_out=1.
REQ-033 tick_in held high 10 cycles in RUN, TICK_COUNT=1 -> exactly one event, seq=1.
REQ-034 ready=0, 8 pulses, TICK_COUNT=4 -> valid held, seq=1, overrun_count_out=1 (macro on) / 0 (macro off).
REQ-035 valid=1, ready=1 coinciding with TICK_COUNT-th edge -> valid stays 1, seq 1->2, overrun 0.
REQ-036 CNT_WIDTH=2, TICK_COUNT=1, 5 accepted events -> seq 1,2,3,0,1.
REQ-037 reset_in pulse mid-RUN with event pending -> same cycle: valid=0, timer_start_out=0, seq=0, busy_out=0; next enable_in -> ARM then RUN.

Source files
------------

// File: rtl/tick_scheduler_if.sv
// +--------------------------------------------------------------------------+
// | tick_scheduler_if : valid/ready event handshake carrying a sequence no.  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface tick_scheduler_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 event_valid_out;
  logic                 event_ready_in;
  logic [CNT_WIDTH-1:0] event_seq_out;

  modport master (
    output event_valid_out,
    output event_seq_out,
    input  event_ready_in
  );

  modport slave (
    input  event_valid_out,
    input  event_seq_out,
    output event_ready_in
  );
endinterface : tick_scheduler_if

`default_nettype wire

// File: rtl/tick_scheduler.sv
// +--------------------------------------------------------------------------+
// | tick_scheduler : counts timer expiries, emits one event per TICK_COUNT.  |
// | Option macro: TICK_SCHEDULER_OVERRUN_CNT_EN (saturating overrun count).  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tick_scheduler #(
  parameter int TICK_COUNT = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  wire logic                 clock_in,
  input  wire logic                 reset_in,
  input  wire logic                 enable_in,
  input  wire logic                 tick_in,
  output logic                      timer_start_out,
  output logic                      busy_out,
  output logic [CNT_WIDTH-1:0]      overrun_count_out,
  tick_scheduler_if.master          evt
);

  localparam int               TICK_W    = 8;
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICK_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic                 tick_prev_q;
  logic                 timer_start_q, timer_start_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [CNT_WIDTH-1:0] seq_q, seq_d;

  logic                 tick_edge;
  logic                 event_gen;

  // A held-high expiry flag must count only once, hence edge detection.
  assign tick_edge = tick_in && !tick_prev_q;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q       <= IDLE;
      tick_cnt_q    <= '0;
      tick_prev_q   <= 1'b0;
      timer_start_q <= 1'b0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      seq_q         <= '0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      tick_prev_q   <= tick_in;
      timer_start_q <= timer_start_d;
      busy_q        <= busy_d;
      valid_q       <= valid_d;
      seq_q         <= seq_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    event_gen  = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_in) state_d = ARM;
      end
      ARM: begin
        tick_cnt_d = '0;
        state_d    = RUN;
      end
      RUN: begin
        if (tick_edge) begin
          if (tick_cnt_q == LAST_TICK) begin
            tick_cnt_d = '0;
            event_gen  = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + 8'd1;
          end
        end
        // Stopping still lets a final-edge event through before clearing.
        if (!enable_in) begin
          state_d    = IDLE;
          tick_cnt_d = '0;
        end
      end
      default: begin
        state_d    = IDLE;
        tick_cnt_d = '0;
      end
    endcase
    timer_start_d = (state_d != IDLE);
    busy_d        = (state_d != IDLE);
  end

  always_comb begin
    valid_d = valid_q;
    seq_d   = seq_q;
    if (event_gen) begin
      // A stalled pending event wins; the new one is dropped.
      if (!valid_q || evt.event_ready_in) begin
        valid_d = 1'b1;
        seq_d   = seq_q + 1'b1;
      end
    end else if (valid_q && evt.event_ready_in) begin
      valid_d = 1'b0;
    end
  end

  assign timer_start_out   = timer_start_q;
  assign busy_out          = busy_q;
  assign evt.event_valid_out = valid_q;
  assign evt.event_seq_out   = seq_q;

`ifdef TICK_SCHEDULER_OVERRUN_CNT_EN
  logic                 event_drop;
  logic [CNT_WIDTH-1:0] overrun_q;

  assign event_drop = event_gen && valid_q && !evt.event_ready_in;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      overrun_q <= '0;
    end else if (event_drop && (overrun_q != {CNT_WIDTH{1'b1}})) begin
      overrun_q <= overrun_q + 1'b1;
    end
  end

  assign overrun_count_out = overrun_q;
`else
  assign overrun_count_out = '0;
`endif

endmodule : tick_scheduler

`default_nettype wire

// File: tb/tb_tick_scheduler.sv
// Directed bench: DUT A uses TICK_COUNT=4/CNT_WIDTH=8, DUT B uses TICK_COUNT=1/CNT_WIDTH=2.
`default_nettype none

module tb_tick_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       ra, ena, tka, tsa, bsa;
  logic [7:0] ova;
  logic       rb, enb, tkb, tsb, bsb;
  logic [1:0] ovb;

  tick_scheduler_if #(.CNT_WIDTH(8)) ifa ();
  tick_scheduler_if #(.CNT_WIDTH(2)) ifb ();

  tick_scheduler #(.TICK_COUNT(4), .CNT_WIDTH(8)) u_dut_a (
    .clock_in          (clk),
    .reset_in          (ra),
    .enable_in         (ena),
    .tick_in           (tka),
    .timer_start_out   (tsa),
    .busy_out          (bsa),
    .overrun_count_out (ova),
    .evt               (ifa)
  );

  tick_scheduler #(.TICK_COUNT(1), .CNT_WIDTH(2)) u_dut_b (
    .clock_in          (clk),
    .reset_in          (rb),
    .enable_in         (enb),
    .tick_in           (tkb),
    .timer_start_out   (tsb),
    .busy_out          (bsb),
    .overrun_count_out (ovb),
    .evt               (ifb)
  );

`ifdef TICK_SCHEDULER_OVERRUN_CNT_EN
  localparam logic [7:0] EXP_OVR = 8'd1;
`else
  localparam logic [7:0] EXP_OVR = 8'd0;
`endif

  int passed = 0;
  int total  = 0;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    ra = 1'b1; rb = 1'b1;
    step(); step();
    total++; if (tsa !== 1'b0) $display("FAIL rst_tstart: got %b expected 0", tsa); else passed++;
    total++; if (bsa !== 1'b0) $display("FAIL rst_busy: got %b expected 0", bsa); else passed++;
    total++; if (ifa.event_valid_out !== 1'b0) $display("FAIL rst_valid: got %b expected 0", ifa.event_valid_out); else passed++;
    total++; if (ifa.event_seq_out !== 8'd0) $display("FAIL rst_seq: got %0d expected 0", ifa.event_seq_out); else passed++;
    total++; if (ova !== 8'd0) $display("FAIL rst_ovr: got %0d expected 0", ova); else passed++;
    total++; if (ifb.event_valid_out !== 1'b0 || ifb.event_seq_out !== 2'd0 || ovb !== 2'd0 || tsb !== 1'b0)
      $display("FAIL rst_b: got valid=%b seq=%0d ovr=%0d ts=%b expected 0", ifb.event_valid_out, ifb.event_seq_out, ovb, tsb);
    else passed++;
    ra = 1'b0; rb = 1'b0;
    step();
    total++; if (bsa !== 1'b0) $display("FAIL idle_hold_busy: got %b expected 0", bsa); else passed++;
  endtask

  task automatic test_single_event;
    ifa.event_ready_in = 1'b1;
    ena = 1'b1;
    step();
    total++; if (tsa !== 1'b1 || bsa !== 1'b1) $display("FAIL arm_outputs: got ts=%b busy=%b expected 1/1", tsa, bsa); else passed++;
    step();
    for (int i = 0; i < 4; i++) begin
      tka = 1'b1; step();
      if (i < 3) begin
        total++; if (ifa.event_valid_out !== 1'b0) $display("FAIL single_early_valid%0d: got %b expected 0", i, ifa.event_valid_out); else passed++;
      end else begin
        total++; if (ifa.event_valid_out !== 1'b1 || ifa.event_seq_out !== 8'd1)
          $display("FAIL single_event: got valid=%b seq=%0d expected 1/1", ifa.event_valid_out, ifa.event_seq_out);
        else passed++;
      end
      tka = 1'b0; step();
    end
    total++; if (ifa.event_valid_out !== 1'b0 || ifa.event_seq_out !== 8'd1)
      $display("FAIL single_accept: got valid=%b seq=%0d expected 0/1", ifa.event_valid_out, ifa.event_seq_out);
    else passed++;
  endtask

  task automatic test_ignored_and_stop;
    ifa.event_ready_in = 1'b0;
    ena = 1'b0;
    step();
    total++; if (tsa !== 1'b0 || bsa !== 1'b0) $display("FAIL stop_outputs: got ts=%b busy=%b expected 0/0", tsa, bsa); else passed++;
    for (int i = 0; i < 4; i++) begin
      tka = 1'b1; step(); tka = 1'b0; step();
    end
    total++; if (ifa.event_valid_out !== 1'b0) $display("FAIL idle_ticks_counted: got valid=%b expected 0", ifa.event_valid_out); else passed++;
    ena = 1'b1; step();
    tka = 1'b1; step();
    tka = 1'b0; step();
    for (int i = 0; i < 3; i++) begin
      tka = 1'b1; step(); tka = 1'b0; step();
    end
    total++; if (ifa.event_valid_out !== 1'b0) $display("FAIL arm_tick_counted: got valid=%b expected 0", ifa.event_valid_out); else passed++;
    tka = 1'b1; ena = 1'b0; step();
    total++; if (ifa.event_valid_out !== 1'b1 || ifa.event_seq_out !== 8'd2 || tsa !== 1'b0 || bsa !== 1'b0)
      $display("FAIL stop_with_event: got valid=%b seq=%0d ts=%b busy=%b expected 1/2/0/0", ifa.event_valid_out, ifa.event_seq_out, tsa, bsa);
    else passed++;
    tka = 1'b0; step(); step();
    total++; if (ifa.event_valid_out !== 1'b1 || ifa.event_seq_out !== 8'd2)
      $display("FAIL pending_in_idle: got valid=%b seq=%0d expected 1/2", ifa.event_valid_out, ifa.event_seq_out);
    else passed++;
    ifa.event_ready_in = 1'b1; step();
    total++; if (ifa.event_valid_out !== 1'b0) $display("FAIL idle_accept: got %b expected 0", ifa.event_valid_out); else passed++;
    ifa.event_ready_in = 1'b0;
  endtask

  task automatic test_overrun;
    ra = 1'b1; step(); ra = 1'b0;
    ena = 1'b1; ifa.event_ready_in = 1'b0;
    step(); step();
    for (int i = 0; i < 8; i++) begin
      tka = 1'b1; step(); tka = 1'b0; step();
      if (i == 3) begin
        total++; if (ifa.event_valid_out !== 1'b1 || ifa.event_seq_out !== 8'd1)
          $display("FAIL ovr_first: got valid=%b seq=%0d expected 1/1", ifa.event_valid_out, ifa.event_seq_out);
        else passed++;
      end
    end
    total++; if (ifa.event_valid_out !== 1'b1 || ifa.event_seq_out !== 8'd1)
      $display("FAIL ovr_hold: got valid=%b seq=%0d expected 1/1", ifa.event_valid_out, ifa.event_seq_out);
    else passed++;
    total++; if (ova !== EXP_OVR) $display("FAIL ovr_count: got %0d expected %0d", ova, EXP_OVR); else passed++;
  endtask

  task automatic test_accept_coincide;
    for (int i = 0; i < 3; i++) begin
      tka = 1'b1; step(); tka = 1'b0; step();
    end
    tka = 1'b1; ifa.event_ready_in = 1'b1; step();
    total++; if (ifa.event_valid_out !== 1'b1 || ifa.event_seq_out !== 8'd2 || ova !== EXP_OVR)
      $display("FAIL coincide: got valid=%b seq=%0d ovr=%0d expected 1/2/%0d", ifa.event_valid_out, ifa.event_seq_out, ova, EXP_OVR);
    else passed++;
    tka = 1'b0; step();
    total++; if (ifa.event_valid_out !== 1'b0) $display("FAIL coincide_drain: got %b expected 0", ifa.event_valid_out); else passed++;
    ifa.event_ready_in = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    for (int i = 0; i < 4; i++) begin
      tka = 1'b1; step(); tka = 1'b0; step();
    end
    total++; if (ifa.event_valid_out !== 1'b1 || ifa.event_seq_out !== 8'd3)
      $display("FAIL pre_reset_pending: got valid=%b seq=%0d expected 1/3", ifa.event_valid_out, ifa.event_seq_out);
    else passed++;
    @(negedge clk);
    ra = 1'b1;
    #1;
    total++; if (ifa.event_valid_out !== 1'b0 || tsa !== 1'b0 || ifa.event_seq_out !== 8'd0 || bsa !== 1'b0 || ova !== 8'd0)
      $display("FAIL async_reset: got valid=%b ts=%b seq=%0d busy=%b ovr=%0d expected all 0", ifa.event_valid_out, tsa, ifa.event_seq_out, bsa, ova);
    else passed++;
    step();
    ra = 1'b0;
    step();
    total++; if (tsa !== 1'b1 || bsa !== 1'b1) $display("FAIL rearm: got ts=%b busy=%b expected 1/1", tsa, bsa); else passed++;
    step();
    ifa.event_ready_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tka = 1'b1; step();
      if (i == 3) begin
        total++; if (ifa.event_valid_out !== 1'b1 || ifa.event_seq_out !== 8'd1)
          $display("FAIL post_reset_event: got valid=%b seq=%0d expected 1/1", ifa.event_valid_out, ifa.event_seq_out);
        else passed++;
      end
      tka = 1'b0; step();
    end
  endtask

  task automatic test_seq_wrap;
    logic [1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    enb = 1'b1; ifb.event_ready_in = 1'b1;
    step(); step();
    total++; if (tsb !== 1'b1 || bsb !== 1'b1) $display("FAIL b_run: got ts=%b busy=%b expected 1/1", tsb, bsb); else passed++;
    for (int i = 0; i < 5; i++) begin
      tkb = 1'b1; step();
      total++; if (ifb.event_valid_out !== 1'b1 || ifb.event_seq_out !== exp_seq[i])
        $display("FAIL wrap_seq%0d: got valid=%b seq=%0d expected 1/%0d", i, ifb.event_valid_out, ifb.event_seq_out, exp_seq[i]);
      else passed++;
      tkb = 1'b0; step();
    end
    total++; if (ifb.event_valid_out !== 1'b0) $display("FAIL wrap_drain: got %b expected 0", ifb.event_valid_out); else passed++;
  endtask

  task automatic test_held_tick;
    int events;
    events = 0;
    rb = 1'b1; step(); rb = 1'b0;
    step(); step();
    tkb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ifb.event_valid_out === 1'b1) events++;
    end
    tkb = 1'b0; step();
    total++; if (events !== 1) $display("FAIL held_tick_events: got %0d expected 1", events); else passed++;
    total++; if (ifb.event_seq_out !== 2'd1) $display("FAIL held_tick_seq: got %0d expected 1", ifb.event_seq_out); else passed++;
  endtask

  initial begin
    ra = 1'b1; ena = 1'b0; tka = 1'b0; ifa.event_ready_in = 1'b0;
    rb = 1'b1; enb = 1'b0; tkb = 1'b0; ifb.event_ready_in = 1'b0;
    test_reset();
    test_single_event();
    test_ignored_and_stop();
    test_overrun();
    test_accept_coincide();
    test_reset_mid_run();
    test_seq_wrap();
    test_held_tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_tick_scheduler

`default_nettype wire
